// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared types and elaboration helpers for the block-RAM FIFO controller.
// Defaults describe the standard 512 x 64 configuration.
package bram_fifo_ctrl_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 512;

  // Occupancy of the 2-entry output queue (0..2).
  typedef logic [1:0] skid_cnt_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Producer/consumer bus of the block-RAM FIFO: write handshake, read handshake,
// synchronous flush and occupancy.
interface bram_fifo_ctrl_if
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = clog2(DEF_DEPTH)
);

  logic                  clear;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [WIDTH-1:0]      rd_data;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output clear, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count
  );

  modport slave (
    input  clear, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count
  );

endinterface

// File: rtl/bram_fifo_out_skid2.sv
// Two-entry output queue that absorbs RAM read data already in flight when the
// consumer stalls; entry 0 is the registered head word.
module bram_fifo_out_skid2
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output skid_cnt_t        skid_cnt
);

  logic [WIDTH-1:0] data_reg  [2];
  logic [WIDTH-1:0] data_next [2];
  skid_cnt_t        cnt_reg;
  skid_cnt_t        cnt_next;
  skid_cnt_t        wr_idx;
  logic             pop;

  assign pop       = out_ready && (cnt_reg != '0);
  assign wr_idx    = cnt_reg - skid_cnt_t'(pop);
  assign cnt_next  = clear ? '0 : (cnt_reg + skid_cnt_t'(in_valid) - skid_cnt_t'(pop));
  assign out_valid = (cnt_reg != '0);
  assign out_data  = data_reg[0];
  assign skid_cnt  = cnt_reg;

  // A pop shifts entries toward the head; the incoming word lands in the first
  // slot left free after that shift.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam int SRC = (gi < 1) ? gi + 1 : gi;
      assign data_next[gi] = (in_valid && (wr_idx == skid_cnt_t'(gi))) ? in_data :
                             (pop ? data_reg[SRC] : data_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      data_reg <= '{default: '0};
    end else begin
      cnt_reg  <= cnt_next;
      data_reg <= data_next;
    end
  end

endmodule

// File: rtl/simple_dual_port_b_ram.sv
// Simple dual-port block RAM: port A writes, port B reads with one cycle of
// registered latency. No reset so that it maps onto a RAM primitive.
module simple_dual_port_b_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [WIDTH-1:0]      d_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [WIDTH-1:0]      d_out
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_a] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      d_out <= mem[addr_b];
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO on one simple dual-port block RAM; the registered read
// latency is hidden behind a 2-entry output queue so push and pop both sustain 1/cycle.
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_fifo_ctrl_if.slave  bus
);

  // DEPTH is a power of two, so the full count is a single MSB.
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   ram_cnt_reg;
  logic [ADDR_WIDTH:0]   ram_cnt_next;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  inflight_reg;
  logic                  push;
  logic                  pop;
  logic                  ren;
  logic                  wr_en;
  logic [2:0]            occ_after_pop;
  skid_cnt_t             skid_cnt;
  logic                  skid_valid;
  logic [WIDTH-1:0]      skid_data;
  logic [WIDTH-1:0]      ram_dout;

  assign bus.wr_ready = (count_reg != FULL_COUNT);
  assign bus.rd_valid = skid_valid;
  assign bus.rd_data  = skid_data;
  assign bus.count    = count_reg;

  assign push  = bus.wr_valid && bus.wr_ready;
  assign pop   = skid_valid && bus.rd_ready;
  assign wr_en = push && !bus.clear;

  // Issue a read only if the queue can still take the word when it returns.
  assign occ_after_pop = {1'b0, skid_cnt} + {2'b0, inflight_reg} - {2'b0, pop};
  assign ren = (ram_cnt_reg != '0) && (occ_after_pop <= 3'd1) && !bus.clear;

  assign ram_cnt_next = ram_cnt_reg + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, ren};
  assign count_next   = count_reg + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      count_reg    <= '0;
      inflight_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + {{(ADDR_WIDTH-1){1'b0}}, push};
      rd_ptr_reg   <= rd_ptr_reg + {{(ADDR_WIDTH-1){1'b0}}, ren};
      ram_cnt_reg  <= ram_cnt_next;
      count_reg    <= count_next;
      inflight_reg <= ren;
    end
  end

  simple_dual_port_b_ram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .addr_a (wr_ptr_reg),
    .d_in   (bus.wr_data),
    .rd_en  (ren),
    .addr_b (rd_ptr_reg),
    .d_out  (ram_dout)
  );

  bram_fifo_out_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.clear),
    .in_valid  (inflight_reg),
    .in_data   (ram_dout),
    .out_valid (skid_valid),
    .out_ready (bus.rd_ready),
    .out_data  (skid_data),
    .skid_cnt  (skid_cnt)
  );

  a_skid_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, skid_cnt} + {2'b0, inflight_reg}) <= 3'd2);

  a_count_sum: assert property (@(posedge clk) disable iff (!rst_n)
    (ram_cnt_reg + {{(ADDR_WIDTH-1){1'b0}}, skid_cnt} + {{ADDR_WIDTH{1'b0}}, inflight_reg}) == count_reg);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl: latency, fill/drain, streaming, random
// backpressure, flush and mid-stream reset, checked against a queue model.
module tb_bram_fifo_ctrl;

  localparam int WIDTH      = 64;
  localparam int DEPTH      = 512;
  localparam int ADDR_WIDTH = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [WIDTH-1:0] q[$];

  bram_fifo_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  bram_fifo_ctrl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head word must match the model whenever the DUT presents one.
  task automatic check_head(input string tag);
    if (bus.rd_valid) begin
      if (q.size() == 0) check({tag, "_spurious"}, 64'(bus.rd_valid), 64'd0);
      else               check(tag, bus.rd_data, q[0]);
    end
  endtask

  // Advance one clock, updating the model with this cycle's handshakes.
  task automatic tick();
    logic do_push;
    logic do_pop;
    do_push = bus.wr_valid && bus.wr_ready;
    do_pop  = bus.rd_valid && bus.rd_ready;
    if (bus.clear) begin
      q.delete();
    end else begin
      if (do_pop && q.size() != 0) void'(q.pop_front());
      if (do_push) q.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    while (q.size() != 0 && guard < 2000) begin
      check_head(tag);
      tick();
      guard++;
    end
    check({tag, "_left"},  64'(q.size()), 64'd0);
    check({tag, "_count"}, 64'(bus.count), 64'd0);
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd0);
    bus.rd_ready = 1'b0;
    $display("step %s: drained in %0d cycles", tag, guard);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check({tag, "_rd_data"},  bus.rd_data,       64'd0);
    check({tag, "_count"},    64'(bus.count),    64'd0);
    check({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_valid;
    int exp_word;
    int guard;
    int n;
    logic stalled;
    logic [WIDTH-1:0] held;

    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;

    // Reset and idle
    #3;
    check_idle("in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("idle");
    $display("step reset: outputs idle");

    // Single word latency: push captured at edge 0, visible after edge 2
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'hA5;
    tick();
    bus.wr_valid = 1'b0;
    check("lat_count1", 64'(bus.count), 64'd1);
    check("lat_valid_e0", 64'(bus.rd_valid), 64'd0);
    tick();
    check("lat_valid_e1", 64'(bus.rd_valid), 64'd0);
    tick();
    check("lat_valid_e2", 64'(bus.rd_valid), 64'd1);
    check("lat_data", bus.rd_data, 64'hA5);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("lat_count0", 64'(bus.count), 64'd0);
    check("lat_empty", 64'(bus.rd_valid), 64'd0);
    $display("step latency: word a5 transferred");

    // Fill to full with no reads
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'(i);
      check("fill_wr_ready", 64'(bus.wr_ready), 64'd1);
      tick();
    end
    check("full_count", 64'(bus.count), 64'd512);
    check("full_wr_ready", 64'(bus.wr_ready), 64'd0);
    bus.wr_data = 64'd513;
    tick();
    check("full_reject_count", 64'(bus.count), 64'd512);
    $display("step fill: 512 words queued, extra word refused");

    // Drain in order; pop while full must not open wr_ready in that cycle
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'hDEAD;
    bus.rd_ready = 1'b1;
    check("full_pop_wr_ready", 64'(bus.wr_ready), 64'd0);
    exp_word = 0;
    guard = 0;
    while (exp_word < DEPTH && guard < 3000) begin
      if (bus.rd_valid) begin
        check("drain_order", bus.rd_data, 64'(exp_word));
        exp_word++;
      end
      tick();
      bus.wr_valid = 1'b0;
      guard++;
    end
    bus.rd_ready = 1'b0;
    check("drain_words", 64'(exp_word), 64'd512);
    check("drain_count", 64'(bus.count), 64'd0);
    $display("step drain: %0d words read back", exp_word);

    // Streaming with both sides always ready
    first_valid = -1;
    for (int c = 0; c < 2000; c++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'h1000 + 64'(c);
      bus.rd_ready = 1'b1;
      if (first_valid >= 0) check("stream_no_gap", 64'(bus.rd_valid), 64'd1);
      if (bus.rd_valid && first_valid < 0) first_valid = c;
      check_head("stream_data");
      tick();
    end
    check("stream_first_valid", 64'(first_valid), 64'd3);
    check("stream_count", 64'(bus.count), 64'd3);
    drain("stream_drain");

    // Random backpressure on both sides
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 10000; c++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data  = {$urandom, $urandom};
      bus.rd_ready = 1'($urandom_range(0, 1));
      check("rand_count", 64'(bus.count), 64'(q.size()));
      check("rand_wr_ready", 64'(bus.wr_ready), 64'(q.size() != DEPTH));
      if (stalled) begin
        check("rand_hold_valid", 64'(bus.rd_valid), 64'd1);
        check("rand_hold_data", bus.rd_data, held);
      end
      check_head("rand_data");
      stalled = bus.rd_valid && !bus.rd_ready;
      held    = bus.rd_data;
      tick();
    end
    drain("rand_drain");

    // Flush with five words queued and a RAM read in flight
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'h50 + 64'(i);
      tick();
    end
    bus.wr_data  = 64'h55;
    bus.rd_ready = 1'b1;
    check("clr_head", bus.rd_data, 64'h50);
    tick();
    check("clr_pre_count", 64'(bus.count), 64'd5);
    bus.clear   = 1'b1;
    bus.wr_data = 64'h77;
    tick();
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("clr_count", 64'(bus.count), 64'd0);
    check("clr_valid", 64'(bus.rd_valid), 64'd0);
    tick();
    check("clr_drop_valid", 64'(bus.rd_valid), 64'd0);
    check("clr_drop_count", 64'(bus.count), 64'd0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'h1;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    tick();
    check("clr_post_valid", 64'(bus.rd_valid), 64'd1);
    check("clr_post_data", bus.rd_data, 64'h1);
    check("clr_post_count", 64'(bus.count), 64'd1);
    drain("clr_drain");

    // Asynchronous reset mid-stream, then refill
    n = $urandom_range(10, 300);
    for (int c = 0; c < n; c++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'h2000 + 64'(c);
      bus.rd_ready = 1'b1;
      check_head("rst_stream_data");
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    q.delete();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("post_reset");
    $display("step reset_mid: reset after %0d cycles", n);
    for (int i = 0; i < 20; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 64'h3000 + 64'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    check("refill_count", 64'(bus.count), 64'd20);
    drain("refill_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
